// File: rtl/lsu_pkg.sv
// Shared LSU definitions: widths, funct3 encodings, exception and write-length codes.
// Also holds the request classifier so every user decodes requests the same way.
package lsu_pkg;

    localparam int          XLEN         = 32;
    localparam int unsigned MEM_SIZE_DEF = 2097152;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd2;
    localparam logic [1:0] EXC_FAULT    = 2'd3;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // Priority illegal > misaligned > fault; the last byte is computed one bit wider so it cannot wrap.
    function automatic logic [1:0] access_exc(
        input logic            is_store,
        input logic [2:0]      funct3,
        input logic [XLEN-1:0] addr,
        input logic [XLEN:0]   limit
    );
        logic            illegal;
        logic            misalign;
        logic [1:0]      size_m1;
        logic [XLEN:0]   last;
        illegal  = is_store ? (funct3 > F3_W) : (funct3 == 3'd3 || funct3[2:1] == 2'b11);
        misalign = (funct3[1:0] == LEN_H && addr[0]) ||
                   (funct3[1:0] == LEN_W && addr[1:0] != 2'b00);
        size_m1  = (funct3[1:0] == LEN_W) ? 2'd3 : funct3[1:0];
        last     = {1'b0, addr} + {{(XLEN-1){1'b0}}, size_m1};
        if (illegal)
            return EXC_ILLEGAL;
        else if (misalign)
            return EXC_MISALIGN;
        else if (last >= limit)
            return EXC_FAULT;
        else
            return EXC_NONE;
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter: sign/zero-extends the LSB-aligned read word by funct3.
// Combinational, no latency; no handshake of its own.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = data;
        case (funct3)
            F3_B:    result = {{(XLEN-8){data[7]}}, data[7:0]};
            F3_BU:   result = {{(XLEN-8){1'b0}}, data[7:0]};
            F3_H:    result = {{(XLEN-16){data[15]}}, data[15:0]};
            F3_HU:   result = {{(XLEN-16){1'b0}}, data[15:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit in front of a sync-read/sync-write byte memory.
// Loads respond 2 cycles after accept, stores/exceptions hold a response until resp_ready.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic [4:0]      resp_rd,
    output logic [1:0]      resp_exc,
    output logic [XLEN-1:0] data_addr_r,
    input  logic [XLEN-1:0] data_r,
    output logic            data_w_en,
    output logic [XLEN-1:0] data_addr_w,
    output logic [XLEN-1:0] data_w,
    output logic [1:0]      data_len_w
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_RD2  = 3'd2;
    localparam logic [2:0] S_ST   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_SIZE);

    logic [2:0]      state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            store_q;
    logic [1:0]      exc_q;
    logic [1:0]      req_exc;
    logic [XLEN-1:0] load_val;

    assign req_exc = access_exc(req_is_store, req_funct3, req_addr, MEM_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            store_q  <= 1'b0;
            exc_q    <= EXC_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        rd_q     <= req_rd;
                        store_q  <= req_is_store;
                        exc_q    <= req_exc;
                        if (req_exc != EXC_NONE)
                            state <= S_RESP;
                        else
                            state <= req_is_store ? S_ST : S_RD1;
                    end
                end
                S_RD1:  state <= S_RD2;
                S_RD2:  if (resp_ready) state <= S_IDLE;
                S_ST:   state <= S_RESP;
                S_RESP: if (resp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    lsu_load_fmt u_load_fmt (
        .funct3 (funct3_q),
        .data   (data_r),
        .result (load_val)
    );

    // Read address stays on addr_q through RD2 so data_r, and therefore resp_rdata, holds under backpressure.
    assign req_ready   = (state == S_IDLE);
    assign resp_valid  = (state == S_RD2) || (state == S_RESP);
    assign resp_rdata  = (state == S_RD2 && !store_q) ? load_val : '0;
    assign resp_rd     = rd_q;
    assign resp_exc    = exc_q;
    assign data_addr_r = addr_q;
    assign data_w_en   = (state == S_ST);
    assign data_addr_w = addr_q;
    assign data_w      = wdata_q;
    assign data_len_w  = funct3_q[1:0];

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a byte-addressed sync memory model.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_exc;
    logic [31:0] data_addr_r;
    logic [31:0] data_r;
    logic        data_w_en;
    logic [31:0] data_addr_w;
    logic [31:0] data_w;
    logic [1:0]  data_len_w;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [int unsigned];

    lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_rd      (resp_rd),
        .resp_exc     (resp_exc),
        .data_addr_r  (data_addr_r),
        .data_r       (data_r),
        .data_w_en    (data_w_en),
        .data_addr_w  (data_addr_w),
        .data_w       (data_w),
        .data_len_w   (data_len_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rb(input int unsigned a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Sync-read, sync-write memory: data_r reflects data_addr_r sampled at the previous edge.
    always @(posedge clk) begin
        data_r <= {rb(data_addr_r + 3), rb(data_addr_r + 2), rb(data_addr_r + 1), rb(data_addr_r)};
        if (data_w_en) begin
            mem[data_addr_w] = data_w[7:0];
            if (data_len_w >= 2'd1) mem[data_addr_w + 1] = data_w[15:8];
            if (data_len_w == 2'd2) begin
                mem[data_addr_w + 2] = data_w[23:16];
                mem[data_addr_w + 3] = data_w[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] exp_d, input logic [1:0] exp_e, input int exp_lat);
        int         lat;
        int         wen;
        logic [1:0] len_seen;
        logic [31:0] waddr_seen;
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd; resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wen = 0; len_seen = 2'd3; waddr_seen = '1;
        do begin
            @(negedge clk);
            lat++;
            if (data_w_en) begin
                wen++;
                len_seen   = data_len_w;
                waddr_seen = data_addr_w;
            end
        end while (!resp_valid && lat < 10);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, resp_rdata, exp_d);
        chk({tag, "_exc"}, 32'(resp_exc), 32'(exp_e));
        chk({tag, "_rd"}, 32'(resp_rd), 32'(rd));
        chk({tag, "_wen_cycles"}, 32'(wen), (st && exp_e == 2'd0) ? 32'd1 : 32'd0);
        if (st && exp_e == 2'd0) begin
            chk({tag, "_len"}, 32'(len_seen), 32'(f3[1:0]));
            chk({tag, "_waddr"}, waddr_seen, a);
        end
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        int          seen;
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b0;
        mem[32'h100] = 8'h01; mem[32'h101] = 8'h7F; mem[32'h102] = 8'hFF; mem[32'h103] = 8'h80;
        mem[32'h200] = 8'h00; mem[32'h201] = 8'h00; mem[32'h202] = 8'h00; mem[32'h203] = 8'h00;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_w_en", 32'(data_w_en), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_exc_rd", {25'd0, resp_exc, resp_rd}, 32'd0);
        chk("rst_addr_r", data_addr_r, 32'd0);
        chk("rst_addr_w", data_addr_w, 32'd0);
        chk("rst_data_w_len", data_w | 32'(data_len_w), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load formatting and latency
        txn("lb_100",  1'b0, 3'd0, 32'h100, 32'h0, 5'd1, 32'h00000001, 2'd0, 2);
        txn("lb_103",  1'b0, 3'd0, 32'h103, 32'h0, 5'd2, 32'hFFFFFF80, 2'd0, 2);
        txn("lbu_102", 1'b0, 3'd4, 32'h102, 32'h0, 5'd3, 32'h000000FF, 2'd0, 2);
        txn("lh_102",  1'b0, 3'd1, 32'h102, 32'h0, 5'd4, 32'hFFFF80FF, 2'd0, 2);
        txn("lhu_102", 1'b0, 3'd5, 32'h102, 32'h0, 5'd5, 32'h000080FF, 2'd0, 2);
        txn("lw_100",  1'b0, 3'd2, 32'h100, 32'h0, 5'd6, 32'h80FF7F01, 2'd0, 2);

        // Store widths
        txn("sb_200",  1'b1, 3'd0, 32'h200, 32'hAABBCCDD, 5'd8,  32'h0, 2'd0, 2);
        txn("lw_sb",   1'b0, 3'd2, 32'h200, 32'h0,        5'd9,  32'h000000DD, 2'd0, 2);
        txn("sh_202",  1'b1, 3'd1, 32'h202, 32'h00001234, 5'd10, 32'h0, 2'd0, 2);
        txn("lw_sh",   1'b0, 3'd2, 32'h200, 32'h0,        5'd11, 32'h123400DD, 2'd0, 2);
        txn("sw_200",  1'b1, 3'd2, 32'h200, 32'hDEADBEEF, 5'd12, 32'h0, 2'd0, 2);
        txn("lw_sw",   1'b0, 3'd2, 32'h200, 32'h0,        5'd13, 32'hDEADBEEF, 2'd0, 2);

        // Exceptions
        txn("lw_mis",   1'b0, 3'd2, 32'h101,    32'h0,  5'd14, 32'h0, 2'd1, 1);
        txn("sh_mis",   1'b1, 3'd1, 32'h203,    32'hFF, 5'd15, 32'h0, 2'd1, 1);
        txn("ld_f3_3",  1'b0, 3'd3, 32'h100,    32'h0,  5'd16, 32'h0, 2'd2, 1);
        txn("st_f3_4",  1'b1, 3'd4, 32'h101,    32'h0,  5'd17, 32'h0, 2'd2, 1);
        txn("lw_fault", 1'b0, 3'd2, 32'h200000, 32'h0,  5'd18, 32'h0, 2'd3, 1);
        txn("lh_edge",  1'b0, 3'd1, 32'h1FFFFE, 32'h0,  5'd19, 32'h0, 2'd0, 2);
        txn("lw_after", 1'b0, 3'd2, 32'h200,    32'h0,  5'd20, 32'hDEADBEEF, 2'd0, 2);

        // Backpressure: resp_ready low for 3 response cycles
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; req_rd = 5'd7;
        resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("bp_rd1_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        held = resp_rdata;
        chk("bp_first_rdata", held, 32'h80FF7F01);
        for (int c = 1; c <= 3; c++) begin
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_rdata", resp_rdata, 32'h80FF7F01);
            chk("bp_hold_rd", 32'(resp_rd), 32'd7);
            chk("bp_hold_req_ready", 32'(req_ready), 32'd0);
            if (c < 3) @(negedge clk);
        end
        @(negedge clk);
        chk("bp_c4_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        req_valid = 1'b1; req_funct3 = 3'd0; req_addr = 32'h103; req_rd = 5'd21;
        @(negedge clk);
        chk("bp_done_valid", 32'(resp_valid), 32'd0);
        chk("bp_done_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_next_accepted", 32'(req_ready), 32'd0);
        chk("bp_next_rd1_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("bp_next_valid", 32'(resp_valid), 32'd1);
        chk("bp_next_rdata", resp_rdata, 32'hFFFFFF80);
        chk("bp_next_rd", 32'(resp_rd), 32'd21);
        @(posedge clk);
        #1 resp_ready = 1'b0;

        // Reset during RD1
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; req_rd = 5'd22;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_rd1_valid", 32'(resp_valid), 32'd0);
        chk("rst_rd1_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("rst_rd1_no_resp", 32'(seen), 32'd0);

        // Reset during ST
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h200;
        req_wdata = 32'h11223344; req_rd = 5'd23;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_st_wen_before", 32'(data_w_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_st_wen_dropped", 32'(data_w_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_st_req_ready", 32'(req_ready), 32'd1);
        chk("rst_st_mem", {rb(32'h203), rb(32'h202), rb(32'h201), rb(32'h200)}, 32'hDEADBEEF);
        txn("lw_rst_st", 1'b0, 3'd2, 32'h200, 32'h0, 5'd24, 32'hDEADBEEF, 2'd0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
